mux4_rr_sched: RTL

MUX4_RR_SCHED -- requirements
Module: mux4_rr_sched

---
 rtl/mux4_rr_sched_pkg.sv | 24 ++
 rtl/mux4to1_8bit.sv | 25 ++
 rtl/mux4_rr_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mux4_rr_sched_pkg.sv
// Shared types and constants for the 4-channel round-robin burst scheduler.
package mux4_rr_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Observable arbiter state, exported so checkers can bind to it.
  typedef struct packed {
    state_t     state;
    logic [1:0] ptr;
    logic [1:0] lock_ch;
    logic [3:0] cnt;
  } dbg_t;

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return ch + 2'd1;
  endfunction

endpackage

// File: rtl/mux4to1_8bit.sv
// 4:1 payload mux; {sel1, sel0} is the channel index with sel1 as MSB.
module mux4to1_8bit
  import mux4_rr_sched_pkg::*;
(
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic              sel1,
  input  logic              sel0,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = d0;
    case ({sel1, sel0})
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler merging four 8-bit channels into one registered
// output stream, with optional per-grant burst locking of up to BURST beats.
module mux4_rr_sched
  import mux4_rr_sched_pkg::*;
#(
  parameter int BURST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [3:0]        in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_chan,
  input  logic              out_ready,
  output dbg_t              dbg
);

  // Handshake: a beat moves on channel i at a rising edge where
  // in_valid[i] && in_ready[i]; the output beat retires where out_valid && out_ready.

  localparam logic [3:0] BURST_CNT = 4'(BURST);

  state_t            state;
  logic [1:0]        ptr;
  logic [1:0]        lock_ch;
  logic [3:0]        cnt;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic              can_load;
  logic              xfer;
  logic [DATA_W-1:0] mux_y;

  // Scan from the highest offset down so the channel closest to ptr wins.
  always_comb begin
    logic [1:0] idx;
    idx         = 2'd0;
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    if (state == HOLD) begin
      grant_valid = in_valid[lock_ch];
      grant_idx   = lock_ch;
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        idx = ptr + 2'(k);
        if (in_valid[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx;
        end
      end
    end
  end

  assign can_load = !out_valid || out_ready;
  // rst_n gates the accept path so no handshake can appear while in reset.
  assign xfer     = rst_n && grant_valid && can_load;
  assign in_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;

  mux4to1_8bit u_mux (
    .d0   (in_data0),
    .d1   (in_data1),
    .d2   (in_data2),
    .d3   (in_data3),
    .sel1 (grant_idx[1]),
    .sel0 (grant_idx[0]),
    .y    (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      ptr       <= 2'd0;
      lock_ch   <= 2'd0;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= 2'd0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_y;
        out_chan  <= grant_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ARB: begin
          if (xfer) begin
            if (BURST == 1) begin
              ptr <= next_ch(grant_idx);
            end else begin
              lock_ch <= grant_idx;
              cnt     <= 4'd1;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          // A locked channel that goes idle forfeits the rest of its burst.
          if (!in_valid[lock_ch]) begin
            ptr   <= next_ch(lock_ch);
            state <= ARB;
          end else if (xfer) begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == BURST_CNT) begin
              ptr   <= next_ch(lock_ch);
              state <= ARB;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign dbg = '{state: state, ptr: ptr, lock_ch: lock_ch, cnt: cnt};

endmodule
